// File: rtl/video_window_3x3.sv
// Streaming 3x3 neighbourhood generator.
// Two line buffers (previous line, two lines back) feed a 3-column shift
// window. Top and left borders are filled by replication so the kernels
// downstream see a full window from the first pixel of a frame.
// Latency from a pixel to its window is exactly two clocks.
module video_window_3x3 #(
   parameter int WIDTH    = 8,
   parameter int LINE_MAX = 4096,
   parameter int ADDR_W   = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_in,
   input  logic             dv_in,
   input  logic             hs_in,
   input  logic             vs_in,
   output logic [WIDTH-1:0] x1,
   output logic [WIDTH-1:0] x2,
   output logic [WIDTH-1:0] x3,
   output logic [WIDTH-1:0] x4,
   output logic [WIDTH-1:0] x5,
   output logic [WIDTH-1:0] x6,
   output logic [WIDTH-1:0] x7,
   output logic [WIDTH-1:0] x8,
   output logic [WIDTH-1:0] x9,
   output logic [WIDTH-1:0] d_out,
   output logic             dv_out,
   output logic             hs_out,
   output logic             vs_out
);

   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_MAX - 1);
   localparam logic [ADDR_W-1:0] COL_ONE  = ADDR_W'(1);

   // position tracking
   logic [ADDR_W-1:0] col_q, col_d;
   logic [1:0]        lcnt_q, lcnt_d;
   logic              seen_q, seen_d;
   logic              hs_prev_q;
   logic              hs_rise_s;
   logic [ADDR_W-1:0] addr_s;
   logic [1:0]        lcnt_eff_s;

   // line buffers: LB1 = previous line, LB2 = two lines back
   logic [WIDTH-1:0]  lb1_mem [LINE_MAX];
   logic [WIDTH-1:0]  lb2_mem [LINE_MAX];

   // stage 1 registers
   logic              p1_dv_q, p1_hs_q, p1_vs_q;
   logic [WIDTH-1:0]  p1_d_q, lb1_q, lb2_q;
   logic              p1_c0_q;
   logic [1:0]        p1_lcnt_q;

   // incoming column after row replication
   logic [WIDTH-1:0]  col_top_s, col_mid_s, col_bot_s;

   // window: index 0..8 maps to x1..x9
   logic [WIDTH-1:0]  win_q [9];
   logic [WIDTH-1:0]  win_d [9];
   logic              dv_out_q, hs_out_q, vs_out_q;

   // A pixel arriving during vertical blanking is treated as line 0, col 0.
   assign hs_rise_s  = hs_in & ~hs_prev_q;
   assign addr_s     = vs_in ? {ADDR_W{1'b0}} : col_q;
   assign lcnt_eff_s = vs_in ? 2'd0 : lcnt_q;

   // Next-state for the column counter, line counter and line-activity flag.
   always_comb begin
      col_d  = col_q;
      lcnt_d = lcnt_q;
      seen_d = seen_q;
      if (vs_in) begin
         col_d  = {ADDR_W{1'b0}};
         lcnt_d = 2'd0;
         seen_d = 1'b0;
      end else if (hs_rise_s) begin
         // a pixel on the same cycle as the edge still counts for this line
         col_d  = {ADDR_W{1'b0}};
         seen_d = 1'b0;
         if ((seen_q || dv_in) && (lcnt_q != 2'd2)) begin
            lcnt_d = lcnt_q + 2'd1;
         end else begin
            lcnt_d = lcnt_q;
         end
      end else if (dv_in) begin
         seen_d = 1'b1;
         if (col_q != COL_LAST) begin
            col_d = col_q + COL_ONE;
         end else begin
            col_d = col_q;
         end
      end else begin
         col_d  = col_q;
         lcnt_d = lcnt_q;
         seen_d = seen_q;
      end
   end

   // Counter and edge-detect state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q     <= {ADDR_W{1'b0}};
         lcnt_q    <= 2'd0;
         seen_q    <= 1'b0;
         hs_prev_q <= 1'b0;
      end else begin
         col_q     <= col_d;
         lcnt_q    <= lcnt_d;
         seen_q    <= seen_d;
         hs_prev_q <= hs_in;
      end
   end

   // Line-buffer write port: new pixel into LB1, displaced LB1 word into LB2.
   always_ff @(posedge clk) begin
      if (dv_in) begin
         lb1_mem[addr_s] <= d_in;
         lb2_mem[addr_s] <= lb1_mem[addr_s];
      end
   end

   // Stage 1: registered RAM reads (old contents) and pixel context.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1_dv_q   <= 1'b0;
         p1_hs_q   <= 1'b0;
         p1_vs_q   <= 1'b0;
         p1_d_q    <= {WIDTH{1'b0}};
         lb1_q     <= {WIDTH{1'b0}};
         lb2_q     <= {WIDTH{1'b0}};
         p1_c0_q   <= 1'b0;
         p1_lcnt_q <= 2'd0;
      end else begin
         p1_dv_q <= dv_in;
         p1_hs_q <= hs_in;
         p1_vs_q <= vs_in;
         if (dv_in) begin
            p1_d_q    <= d_in;
            lb1_q     <= lb1_mem[addr_s];
            lb2_q     <= lb2_mem[addr_s];
            p1_c0_q   <= (addr_s == {ADDR_W{1'b0}});
            p1_lcnt_q <= lcnt_eff_s;
         end else begin
            p1_d_q    <= p1_d_q;
            lb1_q     <= lb1_q;
            lb2_q     <= lb2_q;
            p1_c0_q   <= p1_c0_q;
            p1_lcnt_q <= p1_lcnt_q;
         end
      end
   end

   // Row replication: line 0 copies the current pixel upward, line 1 copies LB1 to the top.
   always_comb begin
      col_bot_s = p1_d_q;
      col_mid_s = lb1_q;
      col_top_s = lb2_q;
      case (p1_lcnt_q)
         2'd0: begin
            col_mid_s = p1_d_q;
            col_top_s = p1_d_q;
         end
         2'd1: begin
            col_mid_s = lb1_q;
            col_top_s = lb1_q;
         end
         default: begin
            col_mid_s = lb1_q;
            col_top_s = lb2_q;
         end
      endcase
   end

   // Window shift with left-border replication. Column 0 fills all three
   // columns, so at column 1 the plain shift already leaves the oldest
   // column equal to the first column.
   always_comb begin
      win_d = win_q;
      if (p1_dv_q) begin
         if (p1_c0_q) begin
            win_d[0] = col_top_s;
            win_d[1] = col_top_s;
            win_d[2] = col_top_s;
            win_d[3] = col_mid_s;
            win_d[4] = col_mid_s;
            win_d[5] = col_mid_s;
            win_d[6] = col_bot_s;
            win_d[7] = col_bot_s;
            win_d[8] = col_bot_s;
         end else begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = col_top_s;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = col_mid_s;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = col_bot_s;
         end
      end else begin
         win_d = win_q;
      end
   end

   // Stage 2: window taps and delayed sync/valid outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= {WIDTH{1'b0}};
         end
         dv_out_q <= 1'b0;
         hs_out_q <= 1'b0;
         vs_out_q <= 1'b0;
      end else begin
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= win_d[i];
         end
         dv_out_q <= p1_dv_q;
         hs_out_q <= p1_hs_q;
         vs_out_q <= p1_vs_q;
      end
   end

   assign x1     = win_q[0];
   assign x2     = win_q[1];
   assign x3     = win_q[2];
   assign x4     = win_q[3];
   assign x5     = win_q[4];
   assign x6     = win_q[5];
   assign x7     = win_q[6];
   assign x8     = win_q[7];
   assign x9     = win_q[8];
   assign d_out  = win_q[4];
   assign dv_out = dv_out_q;
   assign hs_out = hs_out_q;
   assign vs_out = vs_out_q;

endmodule

// File: tb/tb_video_window_3x3.sv
// Directed bench for video_window_3x3. Every step drives one clock of input
// and records the outputs seen just before; the window for the pixel driven
// at step s appears in the record of step s+2.
module tb_video_window_3x3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic       dv_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
   logic [7:0] x1, x2, x3, x4, x5, x6, x7, x8, x9, d_out;
   logic       dv_out, hs_out, vs_out;

   int total = 0;
   int bad   = 0;
   int sn    = 0;

   logic [71:0] hx   [0:16383];
   logic [7:0]  hd   [0:16383];
   logic [2:0]  hctl [0:16383];
   logic [2:0]  ictl [0:16383];

   video_window_3x3 #(.WIDTH(8), .LINE_MAX(4096), .ADDR_W(12)) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .dv_in(dv_in), .hs_in(hs_in), .vs_in(vs_in),
      .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7), .x8(x8), .x9(x9),
      .d_out(d_out), .dv_out(dv_out), .hs_out(hs_out), .vs_out(vs_out)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [7:0] d, input logic dv, input logic hs, input logic vs);
      @(negedge clk);
      hx[sn]   = {x1, x2, x3, x4, x5, x6, x7, x8, x9};
      hd[sn]   = d_out;
      hctl[sn] = {dv_out, hs_out, vs_out};
      d_in  = d;
      dv_in = dv;
      hs_in = hs;
      vs_in = vs;
      ictl[sn] = {dv, hs, vs};
      sn++;
   endtask

   task automatic test_reset();
      int s0;
      for (int i = 0; i < 6; i++) begin
         step(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         total++;
         if ({hx[sn-1], hd[sn-1], hctl[sn-1]} !== 83'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=0", {hx[sn-1], hd[sn-1], hctl[sn-1]});
         end
      end
      step(8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(8'h00, 1'b0, 1'b0, 1'b0);
         total++;
         if ({hx[sn-1], hd[sn-1], hctl[sn-1]} !== 83'd0) begin
            bad++;
            $display("FAIL reset_release got=%h exp=0", {hx[sn-1], hd[sn-1], hctl[sn-1]});
         end
      end
      s0 = sn;
      step(8'h55, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
      total++;
      if (hctl[s0+1] !== 3'b000) begin
         bad++;
         $display("FAIL first_dv_early got=%b exp=000", hctl[s0+1]);
      end
      total++;
      if (hctl[s0+2] !== 3'b100) begin
         bad++;
         $display("FAIL first_dv_lat2 got=%b exp=100", hctl[s0+2]);
      end
      total++;
      if ({hx[s0+2], hd[s0+2]} !== {{9{8'h55}}, 8'h55}) begin
         bad++;
         $display("FAIL first_px_taps got=%h exp=%h", {hx[s0+2], hd[s0+2]}, {{9{8'h55}}, 8'h55});
      end
   endtask

   task automatic test_line0();
      int s0;
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      s0 = sn;
      step(8'd10, 1'b1, 1'b0, 1'b0);
      step(8'd20, 1'b1, 1'b0, 1'b0);
      step(8'd30, 1'b1, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0);
      total++;
      if (hx[s0+2] !== {9{8'd10}}) begin
         bad++;
         $display("FAIL line0_c0 got=%h exp=%h", hx[s0+2], {9{8'd10}});
      end
      total++;
      if (hx[s0+3] !== {3{8'd10, 8'd10, 8'd20}}) begin
         bad++;
         $display("FAIL line0_c1 got=%h exp=%h", hx[s0+3], {3{8'd10, 8'd10, 8'd20}});
      end
      total++;
      if ({hx[s0+4], hd[s0+4]} !== {{3{8'd10, 8'd20, 8'd30}}, 8'd20}) begin
         bad++;
         $display("FAIL line0_c2 got=%h exp=%h", {hx[s0+4], hd[s0+4]}, {{3{8'd10, 8'd20, 8'd30}}, 8'd20});
      end
   endtask

   // Three lines of four pixels, pixel = 16*line + col, with 'gap' idle cycles after each pixel.
   task automatic run_ramp(input int gap, output int p12, output int p20, output int p23);
      p12 = 0; p20 = 0; p23 = 0;
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      for (int l = 0; l < 3; l++) begin
         for (int c = 0; c < 4; c++) begin
            if (l == 1 && c == 2) p12 = sn;
            if (l == 2 && c == 0) p20 = sn;
            if (l == 2 && c == 3) p23 = sn;
            step(8'(16 * l + c), 1'b1, 1'b0, 1'b0);
            for (int g = 0; g < gap; g++) step(8'h00, 1'b0, 1'b0, 1'b0);
         end
         step(8'h00, 1'b0, 1'b1, 1'b0);
         step(8'h00, 1'b0, 1'b1, 1'b0);
         step(8'h00, 1'b0, 1'b0, 1'b0);
      end
   endtask

   localparam logic [71:0] EXP_L1C2 = {8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
   localparam logic [71:0] EXP_L2C0 = {8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20};
   localparam logic [71:0] EXP_L2C3 = {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};

   task automatic test_ramp();
      int p12, p20, p23;
      run_ramp(0, p12, p20, p23);
      total++;
      if (hx[p12+2] !== EXP_L1C2) begin
         bad++;
         $display("FAIL ramp_l1c2 got=%h exp=%h", hx[p12+2], EXP_L1C2);
      end
      total++;
      if (hx[p20+2] !== EXP_L2C0) begin
         bad++;
         $display("FAIL ramp_l2c0 got=%h exp=%h", hx[p20+2], EXP_L2C0);
      end
      total++;
      if ({hx[p23+2], hd[p23+2]} !== {EXP_L2C3, 8'h12}) begin
         bad++;
         $display("FAIL ramp_l2c3 got=%h exp=%h", {hx[p23+2], hd[p23+2]}, {EXP_L2C3, 8'h12});
      end
   endtask

   task automatic test_gappy();
      int p12, p20, p23, st;
      st = sn;
      run_ramp(1, p12, p20, p23);
      total++;
      if (hx[p12+2] !== EXP_L1C2) begin
         bad++;
         $display("FAIL gap_l1c2 got=%h exp=%h", hx[p12+2], EXP_L1C2);
      end
      total++;
      if (hx[p12+3] !== EXP_L1C2) begin
         bad++;
         $display("FAIL gap_hold_l1c2 got=%h exp=%h", hx[p12+3], EXP_L1C2);
      end
      total++;
      if (hx[p20+2] !== EXP_L2C0) begin
         bad++;
         $display("FAIL gap_l2c0 got=%h exp=%h", hx[p20+2], EXP_L2C0);
      end
      total++;
      if ({hx[p23+2], hd[p23+2]} !== {EXP_L2C3, 8'h12}) begin
         bad++;
         $display("FAIL gap_l2c3 got=%h exp=%h", {hx[p23+2], hd[p23+2]}, {EXP_L2C3, 8'h12});
      end
      total++;
      if (hx[p23+3] !== EXP_L2C3) begin
         bad++;
         $display("FAIL gap_hold_l2c3 got=%h exp=%h", hx[p23+3], EXP_L2C3);
      end
      for (int k = st; k < sn - 2; k++) begin
         total++;
         if (hctl[k+2] !== ictl[k]) begin
            bad++;
            $display("FAIL gap_sync_delay step=%0d got=%b exp=%b", k, hctl[k+2], ictl[k]);
         end
      end
   endtask

   task automatic test_edges();
      int s1, s2, s3;
      step(8'h00, 1'b0, 1'b0, 1'b1);
      s1 = sn;
      step(8'h44, 1'b1, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'h61, 1'b1, 1'b0, 1'b0);
      step(8'h62, 1'b1, 1'b0, 1'b0);
      s2 = sn;
      step(8'h63, 1'b1, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      s3 = sn;
      step(8'h65, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
      total++;
      if ({hx[s1+2], hctl[s1+2]} !== {{9{8'h44}}, 3'b101}) begin
         bad++;
         $display("FAIL dv_in_vblank got=%h exp=%h", {hx[s1+2], hctl[s1+2]}, {{9{8'h44}}, 3'b101});
      end
      total++;
      if (hx[s2+2] !== {3{8'h61, 8'h62, 8'h63}}) begin
         bad++;
         $display("FAIL dv_with_hs_edge got=%h exp=%h", hx[s2+2], {3{8'h61, 8'h62, 8'h63}});
      end
      total++;
      if (hx[s3+2] !== {{6{8'h61}}, {3{8'h65}}}) begin
         bad++;
         $display("FAIL col_clear_after_hs got=%h exp=%h", hx[s3+2], {{6{8'h61}}, {3{8'h65}}});
      end
   endtask

   task automatic test_sat_reset();
      int plast, p, s0;
      logic [71:0] exp_sat;
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5000; i++) step(8'(i), 1'b1, 1'b0, 1'b0);
      plast = sn - 1;
      step(8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0);
      total++;
      if (hx[plast+2] !== {3{8'h85, 8'h86, 8'h87}}) begin
         bad++;
         $display("FAIL sat_last_px got=%h exp=%h", hx[plast+2], {3{8'h85, 8'h86, 8'h87}});
      end
      p = 0;
      for (int i = 0; i < 4096; i++) begin
         if (i == 4095) p = sn;
         step(8'hA5, 1'b1, 1'b0, 1'b0);
      end
      step(8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0);
      // LB1[4095] must hold the last pixel of the over-long line (4999 -> 0x87)
      exp_sat = {8'hFD, 8'hFE, 8'h87, 8'hFD, 8'hFE, 8'h87, 8'hA5, 8'hA5, 8'hA5};
      total++;
      if (hx[p+2] !== exp_sat) begin
         bad++;
         $display("FAIL sat_lb_entry got=%h exp=%h", hx[p+2], exp_sat);
      end
      step(8'h33, 1'b1, 1'b0, 1'b0);
      step(8'h34, 1'b1, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step(8'h00, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0);
      total++;
      if ({hx[sn-1], hd[sn-1], hctl[sn-1]} !== 83'd0) begin
         bad++;
         $display("FAIL midframe_reset got=%h exp=0", {hx[sn-1], hd[sn-1], hctl[sn-1]});
      end
      rst = 1'b1;
      step(8'h00, 1'b0, 1'b0, 1'b0);
      s0 = sn;
      step(8'h70, 1'b1, 1'b0, 1'b0);
      step(8'h71, 1'b1, 1'b0, 1'b0);
      step(8'h72, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
      total++;
      if (hx[s0+2] !== {9{8'h70}}) begin
         bad++;
         $display("FAIL after_reset_c0 got=%h exp=%h", hx[s0+2], {9{8'h70}});
      end
      total++;
      if (hx[s0+4] !== {3{8'h70, 8'h71, 8'h72}}) begin
         bad++;
         $display("FAIL after_reset_line0 got=%h exp=%h", hx[s0+4], {3{8'h70, 8'h71, 8'h72}});
      end
   endtask

   initial begin
      test_reset();
      test_line0();
      test_ramp();
      test_gappy();
      test_edges();
      test_sat_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
